// File: rtl/bit4_augment.sv
// 4-bit carry-lookahead adder slice with registered sum and group propagate/generate.
// Optional registered carry-out port is enabled by defining BIT4_AUGMENT_COUT_EN.
module bit4_augment (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic       out_valid,
  output logic [3:0] S,
  output logic       p,
  output logic       g
`ifdef BIT4_AUGMENT_COUT_EN
  ,
  output logic       cout
`endif
);

  localparam int unsigned W = 4;

  logic [W-1:0] bit_g;
  logic [W-1:0] bit_p;
  logic [W-1:0] carry;
  logic [W-1:0] sum_c;
  logic         grp_p_c;
  logic         grp_g_c;

  logic [W-1:0] s_q, s_d;
  logic         p_q, p_d;
  logic         g_q, g_d;
  logic         valid_q, valid_d;

  // Bit terms, flat lookahead carries and group signals (no ripple path).
  always_comb begin
    bit_g    = A & B;
    bit_p    = A ^ B;
    carry[0] = cin;
    carry[1] = bit_g[0] | (bit_p[0] & cin);
    carry[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & cin);
    carry[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
             | (bit_p[2] & bit_p[1] & bit_p[0] & cin);
    sum_c    = bit_p ^ carry;
    grp_p_c  = &bit_p;
    grp_g_c  = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
             | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
  end

  // Results load on a valid cycle and otherwise hold; out_valid marks fresh data only.
  always_comb begin
    s_d     = s_q;
    p_d     = p_q;
    g_d     = g_q;
    valid_d = 1'b0;
    if (in_valid) begin
      s_d     = sum_c;
      p_d     = grp_p_c;
      g_d     = grp_g_c;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      p_q     <= p_d;
      g_q     <= g_d;
      valid_q <= valid_d;
    end
  end

  assign S         = s_q;
  assign p         = p_q;
  assign g         = g_q;
  assign out_valid = valid_q;

`ifdef BIT4_AUGMENT_COUT_EN
  logic cout_q, cout_d;

  always_comb begin
    cout_d = cout_q;
    if (in_valid) begin
      cout_d = grp_g_c | (grp_p_c & cin);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
    end else begin
      cout_q <= cout_d;
    end
  end

  assign cout = cout_q;
`endif

endmodule

// File: tb/tb_bit4_augment.sv
// Scoreboard bench for bit4_augment: arithmetic reference model, expected results queued at drive time.
module tb_bit4_augment;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       cin;
  logic       out_valid;
  logic [3:0] S;
  logic       p;
  logic       g;
`ifdef BIT4_AUGMENT_COUT_EN
  logic       cout;
`endif

  bit4_augment dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .out_valid (out_valid),
    .S         (S),
    .p         (p),
    .g         (g)
`ifdef BIT4_AUGMENT_COUT_EN
    ,
    .cout      (cout)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [3:0] s;
    logic       p;
    logic       g;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [3:0] got, input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      cmp({tag, ".out_valid"}, {3'b0, out_valid}, {3'b0, e.v});
      cmp({tag, ".S"}, S, e.s);
      cmp({tag, ".p"}, {3'b0, p}, {3'b0, e.p});
      cmp({tag, ".g"}, {3'b0, g}, {3'b0, e.g});
`ifdef BIT4_AUGMENT_COUT_EN
      cmp({tag, ".cout"}, {3'b0, cout}, {3'b0, e.c});
`endif
    end
  endtask

  // Drive one cycle on the falling edge, queue the model's post-edge state, check after the rising edge.
  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic ci, input logic iv, input logic r);
    logic [4:0] full;
    logic [4:0] nocin;
    @(negedge clk);
    A = a; B = b; cin = ci; in_valid = iv; rst = r;
    full  = 5'(a) + 5'(b) + 5'(ci);
    nocin = 5'(a) + 5'(b);
    if (r) begin
      model = '0;
    end else if (iv) begin
      model.v = 1'b1;
      model.s = full[3:0];
      model.c = full[4];
      model.p = ((a ^ b) == 4'hF);
      model.g = nocin[4];
    end else begin
      model.v = 1'b0;
    end
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    model = '0;
    rst = 1'b1; in_valid = 1'b1; A = 4'd15; B = 4'd15; cin = 1'b0;

    step("rst0", 4'd15, 4'd15, 1'b0, 1'b1, 1'b1);
    step("rst1", 4'd15, 4'd15, 1'b0, 1'b1, 1'b1);

    step("add_5_6",  4'd5, 4'd6, 1'b0, 1'b1, 1'b0);
    step("add_3_2c", 4'd3, 4'd2, 1'b1, 1'b1, 1'b0);
    step("add_5_2",  4'd5, 4'd2, 1'b0, 1'b1, 1'b0);

    step("wrap_1_15",  4'd1, 4'd15, 1'b0, 1'b1, 1'b0);
    step("wrap_8_8",   4'd8, 4'd8,  1'b0, 1'b1, 1'b0);
    step("add_0_14c",  4'd0, 4'd14, 1'b1, 1'b1, 1'b0);

    step("prop_15_0c", 4'd15, 4'd0, 1'b1, 1'b1, 1'b0);
    step("prop_10_5",  4'd10, 4'd5, 1'b0, 1'b1, 1'b0);
    step("zero",       4'd0,  4'd0, 1'b0, 1'b1, 1'b0);

    step("hold_load", 4'd5, 4'd6, 1'b0, 1'b1, 1'b0);
    step("hold0",     4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    step("hold1",     4'd15, 4'd1, 1'b0, 1'b0, 1'b0);
    step("hold2",     4'd7, 4'd3, 1'b1, 1'b0, 1'b0);
    step("mid_rst",   4'd12, 4'd7, 1'b1, 1'b1, 1'b1);
    step("post_rst",  4'd2, 4'd3, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      step("exh", v[7:4], v[3:0], v[8], 1'b1, 1'b0);
    end

    step("idle_end", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
